// File: rtl/sqr_wave_meas.sv
// Square-wave measurement: hysteresis slicer feeding a phase-length / level FSM.
// Publishes high/low length, period and extreme levels once per complete cycle.
module sqr_wave_meas #(
    parameter int unsigned DT_W    = 8,
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned HYST    = 8,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din_valid,
    input  logic [DT_W-1:0]  din,
    input  logic [DT_W-1:0]  thresh,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period,
    output logic [DT_W-1:0]  v_high,
    output logic [DT_W-1:0]  v_low,
    output logic             no_signal
);

    localparam logic [DT_W:0]    HystExt  = (DT_W+1)'(HYST);
    localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StSync, StHigh, StLow} state_e;

    state_e           state_q;
    logic             lvl_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] lcnt_q;
    logic [CNT_W-1:0] ecnt_q;
    logic [DT_W-1:0]  vmax_q;
    logic [DT_W-1:0]  vmin_q;

    logic [DT_W:0]    th_sum;
    logic [DT_W-1:0]  th_hi;
    logic [DT_W-1:0]  th_lo;
    logic             nxt_lvl;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] ecnt_inc;
    logic             timeout;

    // Thresholds are formed one bit wider so they saturate instead of wrapping.
    always_comb begin
        th_sum  = {1'b0, thresh} + HystExt;
        th_hi   = th_sum[DT_W] ? '1 : th_sum[DT_W-1:0];
        th_lo   = ({1'b0, thresh} > HystExt) ? DT_W'({1'b0, thresh} - HystExt) : '0;
        nxt_lvl = lvl_q;
        if (din >= th_hi) begin
            nxt_lvl = 1'b1;
        end else if (din <= th_lo) begin
            nxt_lvl = 1'b0;
        end
        rise     = din_valid & ~lvl_q & nxt_lvl;
        fall     = din_valid & lvl_q & ~nxt_lvl;
        ecnt_inc = ecnt_q + CntOne;
        timeout  = din_valid && (ecnt_inc == TimeoutC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lvl_q      <= 1'b0;
            hcnt_q     <= '0;
            lcnt_q     <= '0;
            ecnt_q     <= '0;
            vmax_q     <= '0;
            vmin_q     <= '0;
            meas_valid <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            period     <= '0;
            v_high     <= '0;
            v_low      <= '0;
            no_signal  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (din_valid) begin
                lvl_q <= nxt_lvl;
            end
            if (!en) begin
                // Abort: results and no_signal keep their last values.
                state_q <= StIdle;
                hcnt_q  <= '0;
                lcnt_q  <= '0;
                ecnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q <= StSync;
                        hcnt_q  <= '0;
                        lcnt_q  <= '0;
                        ecnt_q  <= '0;
                    end
                    StSync: begin
                        if (din_valid) begin
                            if (rise) begin
                                state_q <= StHigh;
                                hcnt_q  <= CntOne;
                                vmax_q  <= din;
                                ecnt_q  <= '0;
                            end else if (fall) begin
                                ecnt_q <= '0;
                            end else if (timeout) begin
                                no_signal <= 1'b1;
                                hcnt_q    <= '0;
                                lcnt_q    <= '0;
                                ecnt_q    <= '0;
                            end else begin
                                ecnt_q <= ecnt_inc;
                            end
                        end
                    end
                    StHigh: begin
                        if (din_valid) begin
                            if (fall) begin
                                state_q <= StLow;
                                lcnt_q  <= CntOne;
                                vmin_q  <= din;
                                ecnt_q  <= '0;
                            end else if (timeout) begin
                                no_signal <= 1'b1;
                                state_q   <= StSync;
                                hcnt_q    <= '0;
                                lcnt_q    <= '0;
                                ecnt_q    <= '0;
                            end else begin
                                hcnt_q <= hcnt_q + CntOne;
                                ecnt_q <= ecnt_inc;
                                if (din > vmax_q) begin
                                    vmax_q <= din;
                                end
                            end
                        end
                    end
                    StLow: begin
                        if (din_valid) begin
                            if (rise) begin
                                // The rising sample closes this cycle and opens the next one.
                                meas_valid <= 1'b1;
                                no_signal  <= 1'b0;
                                high_len   <= hcnt_q;
                                low_len    <= lcnt_q;
                                period     <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
                                v_high     <= vmax_q;
                                v_low      <= vmin_q;
                                state_q    <= StHigh;
                                hcnt_q     <= CntOne;
                                lcnt_q     <= '0;
                                vmax_q     <= din;
                                ecnt_q     <= '0;
                            end else if (timeout) begin
                                no_signal <= 1'b1;
                                state_q   <= StSync;
                                hcnt_q    <= '0;
                                lcnt_q    <= '0;
                                ecnt_q    <= '0;
                            end else begin
                                lcnt_q <= lcnt_q + CntOne;
                                ecnt_q <= ecnt_inc;
                                if (din < vmin_q) begin
                                    vmin_q <= din;
                                end
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
